// File: rtl/capuccino_if.sv
// Order/response/datapath bundle between the order sources, the arbiter and the shared capuccino datapath.
interface capuccino_if;
   logic       req0;
   logic       req1;
   logic [7:0] lala0;
   logic [7:0] lala1;
   logic [7:0] planch0;
   logic [7:0] planch1;
   logic       ack0;
   logic       ack1;
   logic [7:0] cap_lala;
   logic [7:0] cap_planch;
   logic [7:0] cap_bebida;
   logic       busy;
   logic       resp_valid;
   logic       resp_id;
   logic [7:0] resp_bebida;

   modport slave (
      input  req0, req1, lala0, lala1, planch0, planch1, cap_bebida,
      output ack0, ack1, cap_lala, cap_planch, busy, resp_valid, resp_id, resp_bebida
   );

   modport master (
      output req0, req1, lala0, lala1, planch0, planch1, cap_bebida,
      input  ack0, ack1, cap_lala, cap_planch, busy, resp_valid, resp_id, resp_bebida
   );
endinterface

// File: rtl/capuccino_arbiter.sv
// Two-requester round-robin front end for one shared capuccino datapath.
// Optional served-order counters are built when CAPUCCINO_CNT_EN is defined.
module capuccino_arbiter #(
   parameter int LAT = 1
`ifdef CAPUCCINO_CNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   capuccino_if.slave  bus
`ifdef CAPUCCINO_CNT_EN
   , output logic [CNT_W-1:0] served0
   , output logic [CNT_W-1:0] served1
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic       owner_q, owner_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic [7:0] cap_lala_q, cap_lala_d;
   logic [7:0] cap_planch_q, cap_planch_d;
   logic       busy_q, busy_d;
   logic       resp_valid_q, resp_valid_d;
   logic       resp_id_q, resp_id_d;
   logic [7:0] resp_bebida_q, resp_bebida_d;
   logic       win;
`ifdef CAPUCCINO_CNT_EN
   logic [CNT_W-1:0] served0_q, served0_d;
   logic [CNT_W-1:0] served1_q, served1_d;
`endif

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      ack0_d        = 1'b0;
      ack1_d        = 1'b0;
      cap_lala_d    = cap_lala_q;
      cap_planch_d  = cap_planch_q;
      busy_d        = busy_q;
      resp_valid_d  = 1'b0;
      resp_id_d     = resp_id_q;
      resp_bebida_d = resp_bebida_q;
      win           = 1'b0;
`ifdef CAPUCCINO_CNT_EN
      served0_d     = served0_q;
      served1_d     = served1_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // A lone requester always wins; a tie goes to whoever was not served last.
               win          = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
               ack0_d       = ~win;
               ack1_d       = win;
               cap_lala_d   = win ? bus.lala1   : bus.lala0;
               cap_planch_d = win ? bus.planch1 : bus.planch0;
               owner_d      = win;
               busy_d       = 1'b1;
               cnt_d        = CNT_INIT;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               resp_bebida_d = bus.cap_bebida;
               resp_id_d     = owner_q;
               resp_valid_d  = 1'b1;
               state_d       = DONE;
`ifdef CAPUCCINO_CNT_EN
               if (owner_q) served1_d = served1_q + CNT_W'(1);
               else         served0_d = served0_q + CNT_W'(1);
`endif
            end
         end
         DONE: begin
            last_d  = owner_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_q        <= 1'b1;
         owner_q       <= 1'b0;
         cnt_q         <= 4'd0;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         cap_lala_q    <= 8'd0;
         cap_planch_q  <= 8'd0;
         busy_q        <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_bebida_q <= 8'd0;
`ifdef CAPUCCINO_CNT_EN
         served0_q     <= '0;
         served1_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         ack0_q        <= ack0_d;
         ack1_q        <= ack1_d;
         cap_lala_q    <= cap_lala_d;
         cap_planch_q  <= cap_planch_d;
         busy_q        <= busy_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_bebida_q <= resp_bebida_d;
`ifdef CAPUCCINO_CNT_EN
         served0_q     <= served0_d;
         served1_q     <= served1_d;
`endif
      end
   end

   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.cap_lala    = cap_lala_q;
   assign bus.cap_planch  = cap_planch_q;
   assign bus.busy        = busy_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_id     = resp_id_q;
   assign bus.resp_bebida = resp_bebida_q;
`ifdef CAPUCCINO_CNT_EN
   assign served0 = served0_q;
   assign served1 = served1_q;
`endif

endmodule
